gfx_line_setup: RTL and testbench
=================================

// Module: gfx_line_setup
// PURPOSE
//  Line-setup stage directly upstream of the Bresenham line stepper.
//  - Accepts one line command (two unsigned 16-bit endpoints) over a valid/ready handshake.
//  - Computes the stepper's inputs: major-axis select, absolute deltas and slope direction.
//  - Orders the endpoints so the minor coordinate never decreases.
//  - Drives draw_line to the stepper and releases it exactly when the stepper drops busy.
// PARAMETERS
//  POINT_W  16  width of every coordinate and delta (stepper is fixed at 16)
// PORTS
//  clk_i                   in   1   clock
//  rst_i                   in   1   reset, asynchronous, active-high
//  req_valid_i             in   1   line command valid
//  req_ready_o             out  1   command accepted on valid&ready at posedge
//  x0_i, y0_i, x1_i, y1_i  in   16  endpoints, unsigned screen coords
//  pixel0_x_o, pixel0_y_o  out  16  ordered start point to stepper
//  pixel1_x_o, pixel1_y_o  out  16  ordered end point to stepper
//  delta_major_o           out  16  |major1-major0|
//  delta_minor_o           out  16  |minor1-minor0|
//  x_major_o               out  1   1: x is major axis
//  minor_slope_positive_o  out  1   1: major axis increments; 0: major decrements
//  draw_line_o             out  1   draw request to stepper (combinational from state/busy)
//  line_busy_i             in   1   stepper busy
//  busy_o                  out  1   state != IDLE
//  done_o                  out  1   one-cycle pulse, line finished
// BEHAVIOUR
//  FSM states: IDLE, CALC, START, RUN.
//  - IDLE: req_ready_o=1. On valid&ready, latch x0..y1 -> CALC.
//  - CALC (1 cycle): all 16-bit outputs registered; -> START.
//      x_major = |x1-x0| >= |y1-y0|; ties select x. Differences use 17-bit subtraction.
//      major/minor = (x,y) if x_major, else (y,x).
//      Swap endpoints iff minor1 < minor0 (unsigned); no swap on equality.
//      slope_positive = major1' >= major0' after the swap.
//      Deltas = absolute differences; these always fit in 16 bits.
//  - START: draw_line_o=1. Move to RUN when line_busy_i=1.
//  - RUN: draw_line_o = line_busy_i. When line_busy_i=0, draw_line_o drops in the same cycle,
//      which prevents the stepper from reloading. done_o pulses for that cycle -> IDLE.
//  Timing and bus rules:
//  - Latency: accept at edge N; draw_line_o high in cycle N+2; stepper busy seen in N+3.
//  - Setup outputs hold stable from CALC until the next command is latched.
//  - req_ready_o=0 in CALC/START/RUN (without the optional feature).
//  Boundary cases:
//  - Degenerate line (p0==p1): x_major=1, deltas 0, slope_pos=1, normal RUN/done sequence.
//  - Reset at any point: state IDLE; every output 0 except req_ready_o=1. The stepper is
//      reset with the same rst_i.
//  - valid held in IDLE across done: the new command is accepted on the cycle after done.
// CONFIGURATION
//  GFX_LINE_SETUP_PREFETCH_EN defined:
//  - Adds a 1-entry command buffer. req_ready_o=1 whenever the buffer is empty, including
//      during CALC/START/RUN.
//  - At done_o, a buffered command goes straight to CALC (no IDLE cycle).
//  - Buffered data is not observable on the setup outputs until that CALC.
//  - Reset clears the buffer.
//  Not defined: no buffer; ready only in IDLE.
// TESTING
//  1. (0,0)->(4,2): x_major=1, dmaj=4, dmin=2, slope_pos=1, p0=(0,0), p1=(4,2); draw_line_o
//     high 2 cycles after accept, done_o once.
//  2. (4,2)->(0,0): swapped, identical outputs to test 1.
//  3. (0,4)->(2,0): x_major=0, p0=(0,4), p1=(2,0), dmaj=4, dmin=2, slope_pos=0.
//  4. (5,5)->(5,5): deltas 0, x_major=1, slope_pos=1. Model busy for 2 cycles; draw_line_o
//     falls in the same cycle busy falls; done_o pulses.
//  5. Back-to-back valid with busy modelled 10 cycles:
//     - without macro: ready=0 until IDLE;
//     - with macro: second command accepted during RUN, CALC follows done_o directly.
//  6. rst_i asserted in RUN: next cycle busy_o=0, draw_line_o=0, ready=1, outputs 0.

Source files
------------

// File: rtl/gfx_line_setup.sv
// gfx_line_setup: setup stage in front of the Bresenham line stepper.
// It takes one line command (two endpoints) over a valid/ready handshake.
// It registers the ordered endpoints, the absolute deltas, the major-axis
// select and the slope direction. It then raises draw_line_o and holds it
// while the stepper reports busy.
// Optional feature: define GFX_LINE_SETUP_PREFETCH_EN to add a one-entry
// command buffer. The buffer accepts the next command while a line is in
// flight.
module gfx_line_setup #(
  parameter int POINT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [POINT_W-1:0] x0_i,
  input  logic [POINT_W-1:0] y0_i,
  input  logic [POINT_W-1:0] x1_i,
  input  logic [POINT_W-1:0] y1_i,
  output logic [POINT_W-1:0] pixel0_x_o,
  output logic [POINT_W-1:0] pixel0_y_o,
  output logic [POINT_W-1:0] pixel1_x_o,
  output logic [POINT_W-1:0] pixel1_y_o,
  output logic [POINT_W-1:0] delta_major_o,
  output logic [POINT_W-1:0] delta_minor_o,
  output logic               x_major_o,
  output logic               minor_slope_positive_o,
  output logic               draw_line_o,
  input  logic               line_busy_i,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_START,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic [POINT_W-1:0] x0;
    logic [POINT_W-1:0] y0;
    logic [POINT_W-1:0] x1;
    logic [POINT_W-1:0] y1;
  } cmd_t;

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  cmd_t   req_cmd;
  logic   accept;
  logic   calc_en;

`ifdef GFX_LINE_SETUP_PREFETCH_EN
  cmd_t   buf_q, buf_d;
  logic   buf_valid_q, buf_valid_d;
`endif

  // Setup arithmetic (combinational, evaluated from the latched command)
  logic [POINT_W:0]   dx_s, dy_s;
  logic [POINT_W-1:0] abs_dx, abs_dy;
  logic [POINT_W-1:0] maj0, maj1, min0, min1;
  logic [POINT_W-1:0] maj0_ord, maj1_ord;
  logic               x_major, swap, slope_pos;

  // Registered setup outputs
  logic [POINT_W-1:0] pixel0_x_q, pixel0_x_d;
  logic [POINT_W-1:0] pixel0_y_q, pixel0_y_d;
  logic [POINT_W-1:0] pixel1_x_q, pixel1_x_d;
  logic [POINT_W-1:0] pixel1_y_q, pixel1_y_d;
  logic [POINT_W-1:0] delta_major_q, delta_major_d;
  logic [POINT_W-1:0] delta_minor_q, delta_minor_d;
  logic               x_major_q, x_major_d;
  logic               slope_pos_q, slope_pos_d;

  assign req_cmd = '{x0: x0_i, y0: y0_i, x1: x1_i, y1: y1_i};

`ifdef GFX_LINE_SETUP_PREFETCH_EN
  assign req_ready_o = !buf_valid_q;
`else
  assign req_ready_o = (state_q == ST_IDLE);
`endif

  assign accept = req_valid_i && req_ready_o;
  assign busy_o = (state_q != ST_IDLE);

  // State register and buffer-valid flag
  // NOTE: sequential state uses non-blocking (<=) so that all flops update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
`ifdef GFX_LINE_SETUP_PREFETCH_EN
      buf_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
`ifdef GFX_LINE_SETUP_PREFETCH_EN
      buf_valid_q <= buf_valid_d;
`endif
    end
  end

  // Command payload registers
  // NOTE: payload registers have no reset; the FSM state and buf_valid_q qualify them.
  always_ff @(posedge clk_i) begin
    cmd_q <= cmd_d;
`ifdef GFX_LINE_SETUP_PREFETCH_EN
    buf_q <= buf_d;
`endif
  end

  // Next-state logic, stepper handshake and command capture
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_d     = state_q;
    cmd_d       = cmd_q;
    calc_en     = 1'b0;
    draw_line_o = 1'b0;
    done_o      = 1'b0;
`ifdef GFX_LINE_SETUP_PREFETCH_EN
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    // Any command accepted while a line is in flight goes to the buffer.
    if (accept && (state_q != ST_IDLE)) begin
      buf_d       = req_cmd;
      buf_valid_d = 1'b1;
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d   = req_cmd;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        calc_en = 1'b1;
        state_d = ST_START;
      end
      ST_START: begin
        draw_line_o = 1'b1;
        if (line_busy_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Drop draw_line in the same cycle busy drops so the stepper cannot reload.
        draw_line_o = line_busy_i;
        if (!line_busy_i) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
`ifdef GFX_LINE_SETUP_PREFETCH_EN
          if (buf_valid_q) begin
            cmd_d       = buf_q;
            buf_valid_d = 1'b0;
            state_d     = ST_CALC;
          end else if (accept) begin
            // The buffer is empty and a command arrives on the done cycle: use it directly.
            cmd_d       = req_cmd;
            buf_valid_d = 1'b0;
            state_d     = ST_CALC;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line setup math: major axis, endpoint ordering, slope and deltas
  always_comb begin
    dx_s   = {1'b0, cmd_q.x1} - {1'b0, cmd_q.x0};
    dy_s   = {1'b0, cmd_q.y1} - {1'b0, cmd_q.y0};
    abs_dx = dx_s[POINT_W] ? POINT_W'(-dx_s) : dx_s[POINT_W-1:0];
    abs_dy = dy_s[POINT_W] ? POINT_W'(-dy_s) : dy_s[POINT_W-1:0];

    // Ties select x as the major axis.
    x_major = (abs_dx >= abs_dy);

    if (x_major) begin
      maj0 = cmd_q.x0;
      maj1 = cmd_q.x1;
      min0 = cmd_q.y0;
      min1 = cmd_q.y1;
    end else begin
      maj0 = cmd_q.y0;
      maj1 = cmd_q.y1;
      min0 = cmd_q.x0;
      min1 = cmd_q.x1;
    end

    // Swap so that the minor coordinate never decreases. Equal minors keep the order.
    swap = (min1 < min0);

    if (swap) begin
      pixel0_x_d = cmd_q.x1;
      pixel0_y_d = cmd_q.y1;
      pixel1_x_d = cmd_q.x0;
      pixel1_y_d = cmd_q.y0;
      maj0_ord   = maj1;
      maj1_ord   = maj0;
    end else begin
      pixel0_x_d = cmd_q.x0;
      pixel0_y_d = cmd_q.y0;
      pixel1_x_d = cmd_q.x1;
      pixel1_y_d = cmd_q.y1;
      maj0_ord   = maj0;
      maj1_ord   = maj1;
    end

    slope_pos     = (maj1_ord >= maj0_ord);
    delta_major_d = x_major ? abs_dx : abs_dy;
    delta_minor_d = x_major ? abs_dy : abs_dx;
    x_major_d     = x_major;
    slope_pos_d   = slope_pos;
  end

  // Setup output registers: load in CALC, then hold until the next CALC
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pixel0_x_q    <= '0;
      pixel0_y_q    <= '0;
      pixel1_x_q    <= '0;
      pixel1_y_q    <= '0;
      delta_major_q <= '0;
      delta_minor_q <= '0;
      x_major_q     <= 1'b0;
      slope_pos_q   <= 1'b0;
    end else if (calc_en) begin
      pixel0_x_q    <= pixel0_x_d;
      pixel0_y_q    <= pixel0_y_d;
      pixel1_x_q    <= pixel1_x_d;
      pixel1_y_q    <= pixel1_y_d;
      delta_major_q <= delta_major_d;
      delta_minor_q <= delta_minor_d;
      x_major_q     <= x_major_d;
      slope_pos_q   <= slope_pos_d;
    end
  end

  assign pixel0_x_o             = pixel0_x_q;
  assign pixel0_y_o             = pixel0_y_q;
  assign pixel1_x_o             = pixel1_x_q;
  assign pixel1_y_o             = pixel1_y_q;
  assign delta_major_o          = delta_major_q;
  assign delta_minor_o          = delta_minor_q;
  assign x_major_o              = x_major_q;
  assign minor_slope_positive_o = slope_pos_q;

endmodule

// File: tb/tb_gfx_line_setup.sv
// Directed testbench for gfx_line_setup. A small behavioural stepper model
// holds line_busy_i high for busy_len cycles after it sees draw_line_o.
module tb_gfx_line_setup;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [15:0] x0_i, y0_i, x1_i, y1_i;
  logic [15:0] pixel0_x_o, pixel0_y_o, pixel1_x_o, pixel1_y_o;
  logic [15:0] delta_major_o, delta_minor_o;
  logic        x_major_o, minor_slope_positive_o;
  logic        draw_line_o;
  logic        line_busy_i;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  int busy_len = 2;
  int busy_cnt;

  typedef struct {
    logic [15:0] x0, y0, x1, y1;
    logic [97:0] exp;
  } line_vec_t;

  always #5 clk_i = ~clk_i;

  gfx_line_setup #(.POINT_W(16)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .req_valid_i            (req_valid_i),
    .req_ready_o            (req_ready_o),
    .x0_i                   (x0_i),
    .y0_i                   (y0_i),
    .x1_i                   (x1_i),
    .y1_i                   (y1_i),
    .pixel0_x_o             (pixel0_x_o),
    .pixel0_y_o             (pixel0_y_o),
    .pixel1_x_o             (pixel1_x_o),
    .pixel1_y_o             (pixel1_y_o),
    .delta_major_o          (delta_major_o),
    .delta_minor_o          (delta_minor_o),
    .x_major_o              (x_major_o),
    .minor_slope_positive_o (minor_slope_positive_o),
    .draw_line_o            (draw_line_o),
    .line_busy_i            (line_busy_i),
    .busy_o                 (busy_o),
    .done_o                 (done_o)
  );

  // Stepper model: it starts on draw_line while idle and stays busy for busy_len cycles.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_busy_i <= 1'b0;
      busy_cnt    <= 0;
    end else if (!line_busy_i && draw_line_o) begin
      line_busy_i <= 1'b1;
      busy_cnt    <= busy_len - 1;
    end else if (line_busy_i) begin
      if (busy_cnt == 0) line_busy_i <= 1'b0;
      else               busy_cnt    <= busy_cnt - 1;
    end
  end

  function automatic logic [97:0] obs();
    return {pixel0_x_o, pixel0_y_o, pixel1_x_o, pixel1_y_o,
            delta_major_o, delta_minor_o, x_major_o, minor_slope_positive_o};
  endfunction

  function automatic logic [97:0] pack_exp(input logic [15:0] p0x, p0y, p1x, p1y,
                                           dmaj, dmin, input logic xm, sp);
    return {p0x, p0y, p1x, p1y, dmaj, dmin, xm, sp};
  endfunction

  // Call at a negedge. The task returns at the negedge after the accepting edge (state CALC).
  task automatic issue_cmd(input logic [15:0] a, b, c, d, output bit ok);
    int n;
    ok = 1'b0;
    req_valid_i = 1'b1;
    x0_i = a; y0_i = b; x1_i = c; y1_i = d;
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (req_ready_o) begin
      @(posedge clk_i);
      ok = 1'b1;
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // Call at the CALC negedge (i = 0). The task returns at the negedge where done_o is seen.
  task automatic watch_line(input int max_cyc, output int done_cyc, output int first_draw,
                            output int draw_cyc, output bit done_clean);
    done_cyc = -1; first_draw = -1; draw_cyc = 0; done_clean = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (draw_line_o) begin
        draw_cyc++;
        if (first_draw < 0) first_draw = i;
      end
      if (done_o) begin
        done_cyc   = i;
        done_clean = !draw_line_o && !line_busy_i;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    x0_i = '0; y0_i = '0; x1_i = '0; y1_i = '0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({req_ready_o, busy_o, draw_line_o, done_o} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/busy/draw/done=%b, want 1000",
               {req_ready_o, busy_o, draw_line_o, done_o});
    end
    checks++;
    if (obs() !== 98'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", obs());
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_lines();
    line_vec_t vecs[7];
    bit ok, clean;
    int dc, fd, dw;
    vecs[0] = '{16'd0, 16'd0, 16'd4, 16'd2, pack_exp(0, 0, 4, 2, 4, 2, 1, 1)};
    vecs[1] = '{16'd4, 16'd2, 16'd0, 16'd0, pack_exp(0, 0, 4, 2, 4, 2, 1, 1)};
    vecs[2] = '{16'd0, 16'd4, 16'd2, 16'd0, pack_exp(0, 4, 2, 0, 4, 2, 0, 0)};
    vecs[3] = '{16'd0, 16'd0, 16'd65535, 16'd1, pack_exp(0, 0, 65535, 1, 65535, 1, 1, 1)};
    vecs[4] = '{16'd65535, 16'd0, 16'd0, 16'd65535,
                pack_exp(65535, 0, 0, 65535, 65535, 65535, 1, 0)};
    vecs[5] = '{16'd3, 16'd9, 16'd1, 16'd2, pack_exp(1, 2, 3, 9, 7, 2, 0, 1)};
    vecs[6] = '{16'd7, 16'd9, 16'd7, 16'd1, pack_exp(7, 9, 7, 1, 8, 0, 0, 0)};
    busy_len = 3;
    for (int v = 0; v < 7; v++) begin
      issue_cmd(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, ok);
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL line%0d_accept: ready never seen", v);
      end
      checks++;
`ifdef GFX_LINE_SETUP_PREFETCH_EN
      if ({busy_o, draw_line_o, req_ready_o} !== 3'b101) begin
`else
      if ({busy_o, draw_line_o, req_ready_o} !== 3'b100) begin
`endif
        errors++;
        $display("FAIL line%0d_calc: got busy/draw/ready=%b", v,
                 {busy_o, draw_line_o, req_ready_o});
      end
      watch_line(40, dc, fd, dw, clean);
      checks++;
      if (fd !== 1 || dc !== 5 || dw !== 4 || clean !== 1'b1) begin
        errors++;
        $display("FAIL line%0d_timing: got first_draw=%0d done=%0d draw_cycles=%0d clean=%0d, want 1 5 4 1",
                 v, fd, dc, dw, clean);
      end
      checks++;
      if (obs() !== vecs[v].exp) begin
        errors++;
        $display("FAIL line%0d_setup: got %h, want %h", v, obs(), vecs[v].exp);
      end
      @(negedge clk_i);
      checks++;
      if ({done_o, busy_o, req_ready_o} !== 3'b001) begin
        errors++;
        $display("FAIL line%0d_idle: got done/busy/ready=%b, want 001", v,
                 {done_o, busy_o, req_ready_o});
      end
    end
  endtask

  task automatic test_degenerate();
    bit ok, clean;
    int dc, fd, dw;
    busy_len = 2;
    issue_cmd(16'd5, 16'd5, 16'd5, 16'd5, ok);
    watch_line(40, dc, fd, dw, clean);
    checks++;
    if (ok !== 1'b1 || fd !== 1 || dc !== 4 || dw !== 3 || clean !== 1'b1) begin
      errors++;
      $display("FAIL degen_timing: got ok=%0d first_draw=%0d done=%0d draw_cycles=%0d clean=%0d, want 1 1 4 3 1",
               ok, fd, dc, dw, clean);
    end
    checks++;
    if (obs() !== pack_exp(5, 5, 5, 5, 0, 0, 1, 1)) begin
      errors++;
      $display("FAIL degen_setup: got %h, want %h", obs(), pack_exp(5, 5, 5, 5, 0, 0, 1, 1));
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if ({line_busy_i, busy_o, draw_line_o} !== 3'b000) begin
      errors++;
      $display("FAIL degen_no_reload: got stepper_busy/busy/draw=%b, want 000",
               {line_busy_i, busy_o, draw_line_o});
    end
  endtask

  task automatic test_back_to_back();
    bit ok, clean, seen;
    int dc, fd, dw, ready_cnt;
    logic [97:0] first_exp;
    first_exp = pack_exp(0, 0, 4, 2, 4, 2, 1, 1);
    busy_len = 10;
    issue_cmd(16'd0, 16'd0, 16'd4, 16'd2, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept1: ready never seen");
    end
`ifdef GFX_LINE_SETUP_PREFETCH_EN
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_calc: got %b, want 1", req_ready_o);
    end
    req_valid_i = 1'b1;
    x0_i = 16'd10; y0_i = 16'd3; x1_i = 16'd1; y1_i = 16'd7;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    checks++;
    if ({req_ready_o, busy_o} !== 2'b01 || obs() !== first_exp) begin
      errors++;
      $display("FAIL b2b_buffered: got ready/busy=%b setup=%h, want 01 and %h",
               {req_ready_o, busy_o}, obs(), first_exp);
    end
`else
    req_valid_i = 1'b1;
    x0_i = 16'd10; y0_i = 16'd3; x1_i = 16'd1; y1_i = 16'd7;
`endif
    seen = 1'b0;
    ready_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_ready_o) ready_cnt++;
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    checks++;
    if (seen !== 1'b1 || ready_cnt !== 0) begin
      errors++;
      $display("FAIL b2b_first_run: got done_seen=%0d ready_cycles=%0d, want 1 0", seen, ready_cnt);
    end
    @(negedge clk_i);
`ifndef GFX_LINE_SETUP_PREFETCH_EN
    checks++;
    if ({busy_o, req_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_idle_gap: got busy/ready=%b, want 01", {busy_o, req_ready_o});
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
`endif
    checks++;
    if ({busy_o, draw_line_o, done_o} !== 3'b100 || obs() !== first_exp) begin
      errors++;
      $display("FAIL b2b_calc2: got busy/draw/done=%b setup=%h, want 100 and %h",
               {busy_o, draw_line_o, done_o}, obs(), first_exp);
    end
    watch_line(40, dc, fd, dw, clean);
    checks++;
    if (fd !== 1 || dc !== 12 || clean !== 1'b1) begin
      errors++;
      $display("FAIL b2b_timing2: got first_draw=%0d done=%0d clean=%0d, want 1 12 1", fd, dc, clean);
    end
    checks++;
    if (obs() !== pack_exp(10, 3, 1, 7, 9, 4, 1, 0)) begin
      errors++;
      $display("FAIL b2b_setup2: got %h, want %h", obs(), pack_exp(10, 3, 1, 7, 9, 4, 1, 0));
    end
    @(negedge clk_i);
    checks++;
    if ({busy_o, req_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_final_idle: got busy/ready=%b, want 01", {busy_o, req_ready_o});
    end
  endtask

  task automatic test_reset_in_run();
    bit ok;
    int n;
    busy_len = 10;
    issue_cmd(16'd0, 16'd4, 16'd2, 16'd0, ok);
    n = 0;
    while (!line_busy_i && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    checks++;
    if ({ok, busy_o, line_busy_i, draw_line_o} !== 4'b1111) begin
      errors++;
      $display("FAIL rst_run_reach: got ok/busy/stepper/draw=%b, want 1111",
               {ok, busy_o, line_busy_i, draw_line_o});
    end
    // Offer a command during RUN. With the buffer present it is accepted, and reset must clear it.
    req_valid_i = 1'b1;
    x0_i = 16'd1; y0_i = 16'd1; x1_i = 16'd9; y1_i = 16'd2;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({busy_o, draw_line_o, req_ready_o, done_o} !== 4'b0010 || obs() !== 98'd0) begin
      errors++;
      $display("FAIL rst_run_async: got busy/draw/ready/done=%b setup=%h, want 0010 and 0",
               {busy_o, draw_line_o, req_ready_o, done_o}, obs());
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({busy_o, draw_line_o, req_ready_o, line_busy_i} !== 4'b0010 || obs() !== 98'd0) begin
      errors++;
      $display("FAIL rst_run_after: got busy/draw/ready/stepper=%b setup=%h, want 0010 and 0",
               {busy_o, draw_line_o, req_ready_o, line_busy_i}, obs());
    end
  endtask

  initial begin
    test_reset();
    test_lines();
    test_degenerate();
    test_back_to_back();
    test_reset_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
